// File: rtl/stream_width_packer_pkg.sv
// Shared types and helpers for the stream width packer.
//   pack_state_e : accumulator state (empty / partially filled)
//   idx_width()  : width of the lane index for a given lane count
//   lane_bit()   : one-hot lane mask (1 << idx), truncated by the caller
package stream_width_packer_pkg;

    typedef enum logic {
        ST_EMPTY   = 1'b0,
        ST_FILLING = 1'b1
    } pack_state_e;

    function automatic int unsigned idx_width(input int unsigned ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    function automatic logic [31:0] lane_bit(input int unsigned idx);
        return 32'd1 << idx;
    endfunction

endpackage

// File: rtl/stream_width_packer.sv
// Packs RATIO consecutive narrow beats into one wide word.
// A word closes on the last lane or on in_last; an optional idle timeout
// flushes a partial word so it never waits forever for more input.
// Ports:
//   clk, rstn (sync active-low), clear (sync flush-and-discard)
//   in_data/in_valid/in_last/in_ready    : narrow input stream
//   out_data/out_keep/out_last/out_valid/out_ready : wide output stream
//   pending : a partial word sits in the accumulator
module stream_width_packer
    import stream_width_packer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned RATIO         = 4,
    parameter int unsigned FLUSH_TIMEOUT = 0
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        clear,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic                        in_valid,
    input  logic                        in_last,
    output logic                        in_ready,
    output logic [DATA_WIDTH*RATIO-1:0] out_data,
    output logic [RATIO-1:0]            out_keep,
    output logic                        out_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        pending
);

    localparam int unsigned IW      = idx_width(RATIO);
    localparam int unsigned TMO_LIM = (FLUSH_TIMEOUT > 0) ? FLUSH_TIMEOUT - 1 : 0;
    localparam int unsigned TW      = (TMO_LIM > 0) ? $clog2(TMO_LIM + 1) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(RATIO - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TMO_LIM);

    pack_state_e                        state, state_nxt;
    logic [IW-1:0]                      idx;
    logic [RATIO-1:0][DATA_WIDTH-1:0]   acc_data, acc_data_nxt, out_reg;
    logic [RATIO-1:0]                   acc_keep, acc_keep_nxt;
    logic [TW-1:0]                      tmo_cnt;
    logic                               kill, in_exec, close, flush;

    assign kill     = !rstn || clear;
    assign in_ready = !out_valid || out_ready;
    assign in_exec  = in_valid && in_ready;
    assign close    = in_exec && ((idx == LAST_IDX) || in_last);
    // The flush needs a free output register; an accepted beat wins.
    assign flush    = (FLUSH_TIMEOUT != 0) && (state == ST_FILLING) && !in_exec &&
                      (tmo_cnt == TMO_MAX) && in_ready;
    assign out_data = out_reg;

    // Accumulator view including the beat accepted this cycle, so a closing
    // beat lands in the output register without an extra cycle.
    always_comb begin
        acc_data_nxt = acc_data;
        acc_keep_nxt = acc_keep;
        if (in_exec) begin
            acc_data_nxt[idx] = in_data;
            acc_keep_nxt      = acc_keep | RATIO'(lane_bit(32'(idx)));
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (kill) state <= ST_EMPTY;
        else      state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY:   if (in_exec && !close) state_nxt = ST_FILLING;
            ST_FILLING: if (close || flush)    state_nxt = ST_EMPTY;
            default:                           state_nxt = ST_EMPTY;
        endcase
    end

    // FSM: outputs
    always_comb begin
        pending = (state == ST_FILLING);
    end

    always_ff @(posedge clk) begin
        if (kill) begin
            idx       <= '0;
            acc_data  <= '0;
            acc_keep  <= '0;
            tmo_cnt   <= '0;
            out_valid <= 1'b0;
            out_reg   <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (close || flush) begin
                // A new word may overwrite one being consumed this cycle,
                // keeping out_valid high for a bubble-free stream.
                out_reg   <= acc_data_nxt;
                out_keep  <= acc_keep_nxt;
                out_last  <= close && in_last;
                out_valid <= 1'b1;
                idx       <= '0;
                acc_data  <= '0;
                acc_keep  <= '0;
            end else begin
                if (out_valid && out_ready) out_valid <= 1'b0;
                if (in_exec) begin
                    idx      <= idx + IW'(1);
                    acc_data <= acc_data_nxt;
                    acc_keep <= acc_keep_nxt;
                end
            end

            // Idle counter saturates so a blocked flush fires on the first free cycle.
            if (in_exec || close || flush || state == ST_EMPTY) tmo_cnt <= '0;
            else if (tmo_cnt != TMO_MAX)                       tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

endmodule

// File: tb/tb_stream_width_packer.sv
module tb_stream_width_packer;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } word_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        clear = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready, out_last, out_valid, pending;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        in_ready5, out_last5, out_valid5, pending5;
    logic [31:0] out_data5;
    logic [3:0]  out_keep5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_width_packer #(.DATA_WIDTH(8), .RATIO(4), .FLUSH_TIMEOUT(0)) dut (
        .clk(clk), .rstn(rstn), .clear(clear),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .pending(pending)
    );

    stream_width_packer #(.DATA_WIDTH(8), .RATIO(4), .FLUSH_TIMEOUT(5)) dut5 (
        .clk(clk), .rstn(rstn), .clear(clear),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready5),
        .out_data(out_data5), .out_keep(out_keep5), .out_last(out_last5),
        .out_valid(out_valid5), .out_ready(out_ready), .pending(pending5)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic do_clear();
        idle_inputs();
        out_ready = 1'b1;
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h5A;
        repeat (3) step();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_keep !== 4'h0 ||
            out_last !== 1'b0 || pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b d=%h k=%h l=%b p=%b, want all zero",
                     out_valid, out_data, out_keep, out_last, pending);
        end
        step();
        rstn = 1'b1;
        idle_inputs();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || pending !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: got v=%b p=%b rdy=%b, want v=0 p=0 rdy=1",
                     out_valid, pending, in_ready);
        end
        step();
    endtask

    task automatic test_full_words();
        do_clear();
        for (int k = 1; k <= 8; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(k);
            in_last  = 1'b0;
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL full_no_stall beat %0d: in_ready=%b want 1", k, in_ready);
            end
            if (k == 5) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== 32'h04030201 || out_keep !== 4'hF ||
                    out_last !== 1'b0 || pending !== 1'b0) begin
                    errors++;
                    $display("FAIL full_word1: got v=%b d=%h k=%h l=%b p=%b, want 1 04030201 f 0 0",
                             out_valid, out_data, out_keep, out_last, pending);
                end
            end else if (k > 5) begin
                checks++;
                if (out_valid !== 1'b0 || pending !== 1'b1) begin
                    errors++;
                    $display("FAIL full_gap beat %0d: got v=%b p=%b want v=0 p=1", k, out_valid, pending);
                end
            end
            step();
        end
        idle_inputs();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h08070605 || out_keep !== 4'hF || out_last !== 1'b0) begin
            errors++;
            $display("FAIL full_word2: got v=%b d=%h k=%h l=%b, want 1 08070605 f 0",
                     out_valid, out_data, out_keep, out_last);
        end
        step();
    endtask

    task automatic test_last();
        logic [7:0] seq [6];
        logic       lst [6];
        seq = '{8'hAA, 8'hBB, 8'h01, 8'h02, 8'h03, 8'h04};
        lst = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        do_clear();
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = seq[i];
            in_last  = lst[i];
            @(negedge clk);
            if (i == 1) begin
                checks++;
                if (pending !== 1'b1 || out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL last_pending: got p=%b v=%b want p=1 v=0", pending, out_valid);
                end
            end
            if (i == 2) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== 32'h0000BBAA || out_keep !== 4'h3 ||
                    out_last !== 1'b1 || pending !== 1'b0) begin
                    errors++;
                    $display("FAIL last_short: got v=%b d=%h k=%h l=%b p=%b, want 1 0000bbaa 3 1 0",
                             out_valid, out_data, out_keep, out_last, pending);
                end
            end
            step();
        end
        idle_inputs();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h04030201 || out_keep !== 4'hF || out_last !== 1'b1) begin
            errors++;
            $display("FAIL last_full_lane: got v=%b d=%h k=%h l=%b, want 1 04030201 f 1",
                     out_valid, out_data, out_keep, out_last);
        end
        step();
    endtask

    task automatic test_backpressure();
        logic [7:0]  beats [64];
        word_t       exp_q [$];
        word_t       got;
        int          sent = 0;
        int          rcvd = 0;
        int          cyc = 0;
        logic        stall = 1'b0;
        logic [31:0] pd;
        logic [3:0]  pk;
        logic        pl;
        do_clear();
        for (int w = 0; w < 16; w++) begin
            word_t e;
            e.d = '0;
            for (int j = 0; j < 4; j++) begin
                beats[w*4+j] = 8'($urandom);
                e.d[j*8 +: 8] = beats[w*4+j];
            end
            e.k = 4'hF;
            e.l = 1'b0;
            exp_q.push_back(e);
        end
        while (rcvd < 16 && cyc < 400) begin
            out_ready = (cyc >= 10);
            in_valid  = (sent < 64);
            in_data   = (sent < 64) ? beats[sent] : 8'h00;
            in_last   = 1'b0;
            @(negedge clk);
            if (cyc == 6) begin
                checks++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_stall: got rdy=%b v=%b want rdy=0 v=1", in_ready, out_valid);
                end
            end
            if (stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== pd || out_keep !== pk || out_last !== pl) begin
                    errors++;
                    $display("FAIL bp_hold: got v=%b d=%h k=%h l=%b, want 1 %h %h %b",
                             out_valid, out_data, out_keep, out_last, pd, pk, pl);
                end
            end
            if (out_valid && out_ready) begin
                got = exp_q.pop_front();
                rcvd++;
                checks++;
                if (out_data !== got.d || out_keep !== got.k || out_last !== got.l) begin
                    errors++;
                    $display("FAIL bp_word %0d: got d=%h k=%h l=%b, want d=%h k=%h l=%b",
                             rcvd, out_data, out_keep, out_last, got.d, got.k, got.l);
                end
            end
            if (in_valid && in_ready) sent++;
            stall = out_valid && !out_ready;
            pd = out_data; pk = out_keep; pl = out_last;
            step();
            cyc++;
        end
        idle_inputs();
        out_ready = 1'b1;
        checks++;
        if (rcvd != 16 || sent != 64) begin
            errors++;
            $display("FAIL bp_count: got words=%0d beats=%0d, want 16 and 64", rcvd, sent);
        end
        step();
    endtask

    task automatic test_clear();
        do_clear();
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hE0 + 8'(i);
            step();
        end
        idle_inputs();
        clear = 1'b1;
        @(negedge clk);
        checks++;
        if (pending !== 1'b1) begin
            errors++;
            $display("FAIL clear_pre: pending=%b want 1", pending);
        end
        step();
        clear = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(k);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || (k == 1 && pending !== 1'b0)) begin
                errors++;
                $display("FAIL clear_discard beat %0d: got v=%b p=%b want v=0", k, out_valid, pending);
            end
            step();
        end
        idle_inputs();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h04030201 || out_keep !== 4'hF || out_last !== 1'b0) begin
            errors++;
            $display("FAIL clear_after: got v=%b d=%h k=%h l=%b, want 1 04030201 f 0",
                     out_valid, out_data, out_keep, out_last);
        end
        step();
    endtask

    task automatic test_timeout();
        logic [7:0] seq [3];
        seq = '{8'h11, 8'h22, 8'h33};
        do_clear();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = seq[i];
            step();
        end
        idle_inputs();
        for (int t = 1; t <= 6; t++) begin
            @(negedge clk);
            if (t <= 5) begin
                checks++;
                if (out_valid5 !== 1'b0 || pending5 !== 1'b1) begin
                    errors++;
                    $display("FAIL tmo_wait idle %0d: got v=%b p=%b want v=0 p=1", t, out_valid5, pending5);
                end
            end else begin
                checks++;
                if (out_valid5 !== 1'b1 || out_data5 !== 32'h00332211 || out_keep5 !== 4'h7 ||
                    out_last5 !== 1'b0 || pending5 !== 1'b0) begin
                    errors++;
                    $display("FAIL tmo_flush: got v=%b d=%h k=%h l=%b p=%b, want 1 00332211 7 0 0",
                             out_valid5, out_data5, out_keep5, out_last5, pending5);
                end
            end
            step();
        end
        // The timeout-free instance must still be holding the partial word.
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || pending !== 1'b1) begin
            errors++;
            $display("FAIL tmo_disabled: got v=%b p=%b want v=0 p=1", out_valid, pending);
        end
        step();
    endtask

    task automatic test_random();
        word_t       exp_q [$];
        word_t       got, nw;
        logic [31:0] md = '0;
        int          mn = 0;
        int          sent = 0;
        int          out_beats = 0;
        int          cyc = 0;
        logic        stall = 1'b0;
        logic [31:0] pd;
        logic [3:0]  pk;
        logic        pl;
        do_clear();
        while ((sent < 10000 || exp_q.size() != 0 || mn != 0) && cyc < 60000) begin
            in_valid  = (sent < 10000) && ($urandom_range(0, 9) < 7);
            in_data   = 8'($urandom);
            in_last   = ($urandom_range(0, 7) == 0) || (sent == 9999);
            out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            checks++;
            if (pending !== (mn != 0) || in_ready !== (!out_valid || out_ready)) begin
                errors++;
                $display("FAIL rnd_status cyc %0d: got p=%b rdy=%b, want p=%b rdy=%b",
                         cyc, pending, in_ready, (mn != 0), (!out_valid || out_ready));
            end
            if (stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== pd || out_keep !== pk || out_last !== pl) begin
                    errors++;
                    $display("FAIL rnd_hold cyc %0d: got v=%b d=%h, want 1 %h", cyc, out_valid, out_data, pd);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_extra cyc %0d: got d=%h, want no word", cyc, out_data);
                end else begin
                    got = exp_q.pop_front();
                    if (out_data !== got.d || out_keep !== got.k || out_last !== got.l) begin
                        errors++;
                        $display("FAIL rnd_word cyc %0d: got d=%h k=%h l=%b, want d=%h k=%h l=%b",
                                 cyc, out_data, out_keep, out_last, got.d, got.k, got.l);
                    end
                end
                out_beats += $countones(out_keep);
            end
            if (in_valid && in_ready) begin
                md[mn*8 +: 8] = in_data;
                mn++;
                sent++;
                if (mn == 4 || in_last) begin
                    nw.d = md;
                    nw.k = 4'((1 << mn) - 1);
                    nw.l = in_last;
                    exp_q.push_back(nw);
                    md = '0;
                    mn = 0;
                end
            end
            stall = out_valid && !out_ready;
            pd = out_data; pk = out_keep; pl = out_last;
            step();
            cyc++;
        end
        idle_inputs();
        out_ready = 1'b1;
        checks++;
        if (cyc >= 60000 || out_beats != sent || sent != 10000) begin
            errors++;
            $display("FAIL rnd_conserve: got sent=%0d out_beats=%0d cyc=%0d, want 10000 10000 <60000",
                     sent, out_beats, cyc);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_full_words();
        test_last();
        test_backpressure();
        test_clear();
        test_timeout();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
